// File: rtl/spi_master.sv
// SPI mode-0 master: shifts one NBITS frame out MSB-first on MOSI while
// capturing MISO, then offers the received word on a val/rdy response port.
module spi_master #(
  parameter int NBITS = 34,
  parameter int HALF  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_val,
  output logic             req_rdy,
  input  logic [NBITS-1:0] req_msg,
  output logic             resp_val,
  input  logic             resp_rdy,
  output logic [NBITS-1:0] resp_msg,
  output logic             spi_cs,
  output logic             spi_sclk,
  output logic             spi_mosi,
  input  logic             spi_miso,
  output logic             busy
);

  // state | meaning
  // IDLE  | waiting for a request, req_rdy high
  // LEAD  | cs low, first bit on MOSI, sclk low for one half-period
  // HI    | sclk high; MISO was sampled on entry
  // LO    | sclk low; MOSI advanced on entry
  // TRAIL | cs still low after the last falling edge
  // GAP   | cs high, minimum deselect time
  // RESP  | received word offered until the consumer takes it
  typedef enum logic [2:0] {IDLE, LEAD, HI, LO, TRAIL, GAP, RESP} state_t;

  localparam int CW = $clog2(NBITS);
  localparam int TW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [TW-1:0] TLOAD = TW'(HALF - 1);
  localparam logic [CW-1:0] LAST  = CW'(NBITS - 1);

  state_t           state, state_nx;
  logic [TW-1:0]    timer, timer_nx;
  logic [CW-1:0]    bit_cnt, bit_cnt_nx;
  logic [NBITS-1:0] tx_sh, tx_sh_nx;
  logic [NBITS-1:0] rx_sh, rx_sh_nx;
  logic             cs_nx, sclk_nx, mosi_nx;
  logic             tmr_done;

  assign tmr_done = (timer == '0);

  always_comb begin
    state_nx   = state;
    timer_nx   = timer;
    bit_cnt_nx = bit_cnt;
    tx_sh_nx   = tx_sh;
    rx_sh_nx   = rx_sh;
    cs_nx      = spi_cs;
    sclk_nx    = spi_sclk;
    mosi_nx    = spi_mosi;
    if (state != IDLE && state != RESP && !tmr_done)
      timer_nx = timer - 1'b1;
    case (state)
      IDLE: begin
        if (req_val) begin
          state_nx   = LEAD;
          timer_nx   = TLOAD;
          bit_cnt_nx = '0;
          tx_sh_nx   = req_msg;
          cs_nx      = 1'b0;
          sclk_nx    = 1'b0;
          mosi_nx    = req_msg[NBITS-1];
        end
      end
      LEAD, LO: begin
        if (tmr_done) begin
          state_nx = HI;
          timer_nx = TLOAD;
          sclk_nx  = 1'b1;
          rx_sh_nx = {rx_sh[NBITS-2:0], spi_miso};
        end
      end
      HI: begin
        if (tmr_done) begin
          timer_nx = TLOAD;
          sclk_nx  = 1'b0;
          if (bit_cnt == LAST) begin
            state_nx = TRAIL;
          end else begin
            state_nx   = LO;
            tx_sh_nx   = tx_sh << 1;
            mosi_nx    = tx_sh[NBITS-2];
            bit_cnt_nx = bit_cnt + 1'b1;
          end
        end
      end
      TRAIL: begin
        if (tmr_done) begin
          state_nx = GAP;
          timer_nx = TLOAD;
          cs_nx    = 1'b1;
          mosi_nx  = 1'b0;
        end
      end
      GAP: begin
        if (tmr_done) state_nx = RESP;
      end
      RESP: begin
        if (resp_rdy) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      timer    <= '0;
      bit_cnt  <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      spi_cs   <= 1'b1;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
    end else begin
      state    <= state_nx;
      timer    <= timer_nx;
      bit_cnt  <= bit_cnt_nx;
      tx_sh    <= tx_sh_nx;
      rx_sh    <= rx_sh_nx;
      spi_cs   <= cs_nx;
      spi_sclk <= sclk_nx;
      spi_mosi <= mosi_nx;
    end
  end

  assign req_rdy  = (state == IDLE);
  assign resp_val = (state == RESP);
  assign resp_msg = rx_sh;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: one instance at HALF=2 (loopback and
// minion model), one at HALF=1 for back-to-back throughput.
module tb_spi_master;
  localparam int N = 34;
  localparam int LAT_A = 2 * (2 * N + 2);
  localparam int LAT_B = 1 * (2 * N + 2);

  typedef struct {
    logic [N-1:0] msg;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t qa[$];
  exp_t qb[$];

  logic         a_req_val, a_req_rdy, a_resp_val, a_resp_rdy;
  logic [N-1:0] a_req_msg, a_resp_msg;
  logic         a_cs, a_sclk, a_mosi, a_miso, a_busy;
  logic         b_req_val, b_req_rdy, b_resp_val, b_resp_rdy;
  logic [N-1:0] b_req_msg, b_resp_msg;
  logic         b_cs, b_sclk, b_mosi, b_miso, b_busy;

  logic         a_loop = 1'b1;
  logic [N-1:0] a_reply = '0;
  logic [N-1:0] a_mshift = '0;
  logic [N-1:0] a_tx = '0;

  spi_master #(.NBITS(N), .HALF(2)) dut_a (
    .clk(clk), .reset(reset),
    .req_val(a_req_val), .req_rdy(a_req_rdy), .req_msg(a_req_msg),
    .resp_val(a_resp_val), .resp_rdy(a_resp_rdy), .resp_msg(a_resp_msg),
    .spi_cs(a_cs), .spi_sclk(a_sclk), .spi_mosi(a_mosi), .spi_miso(a_miso),
    .busy(a_busy)
  );

  spi_master #(.NBITS(N), .HALF(1)) dut_b (
    .clk(clk), .reset(reset),
    .req_val(b_req_val), .req_rdy(b_req_rdy), .req_msg(b_req_msg),
    .resp_val(b_resp_val), .resp_rdy(b_resp_rdy), .resp_msg(b_resp_msg),
    .spi_cs(b_cs), .spi_sclk(b_sclk), .spi_mosi(b_mosi), .spi_miso(b_miso),
    .busy(b_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Mode-0 minion: first bit valid at cs fall, next bit after each sclk fall.
  assign a_miso = a_loop ? a_mosi : a_mshift[N-1];
  assign b_miso = b_mosi;
  always @(negedge a_cs) a_mshift = a_reply;
  always @(negedge a_sclk) if (!a_cs) a_mshift = a_mshift << 1;

  // Frame monitor A: sclk rises, MOSI bit sequence, MOSI stable while sclk high.
  logic         a_psclk = 1'b0, a_pcs = 1'b1, a_pmosi = 1'b0;
  int           a_rises = 0, a_mosi_bad = 0;
  logic [N-1:0] a_bits = '0;
  always @(negedge clk) begin
    if (!reset) begin
      a_rises = 0;
      a_mosi_bad = 0;
    end else if (!a_cs) begin
      if (a_pcs) begin
        a_rises = 0;
        a_mosi_bad = 0;
        a_bits = '0;
      end
      if (a_sclk && !a_psclk) begin
        a_bits = {a_bits[N-2:0], a_mosi};
        a_rises++;
      end
      if (a_sclk && a_psclk && a_mosi !== a_pmosi) a_mosi_bad++;
    end else if (!a_pcs) begin
      check("a_sclk_rises", 64'(a_rises), 64'(N));
      check("a_mosi_bits", 64'(a_bits), 64'(a_tx));
      check("a_mosi_stable", 64'(a_mosi_bad), 64'd0);
    end
    a_psclk = a_sclk;
    a_pcs   = a_cs;
    a_pmosi = a_mosi;
  end

  // Frame monitor B: sclk rises per frame and deselect gap between frames.
  logic b_psclk = 1'b0, b_pcs = 1'b1;
  int   b_rises = 0, b_gap = 0, b_frames = 0;
  always @(negedge clk) begin
    if (!reset) begin
      b_rises = 0;
      b_gap = 0;
    end else if (!b_cs) begin
      if (b_pcs) begin
        if (b_frames > 0) check("b_cs_gap_min", 64'(b_gap >= 1), 64'd1);
        b_rises = 0;
      end
      if (b_sclk && !b_psclk) b_rises++;
    end else begin
      if (!b_pcs) begin
        check("b_sclk_rises", 64'(b_rises), 64'(N));
        b_frames++;
        b_gap = 0;
      end
      b_gap++;
    end
    b_psclk = b_sclk;
    b_pcs   = b_cs;
  end

  // Response monitors: latency on resp_val rise, payload on handshake.
  logic a_pval = 1'b0, b_pval = 1'b0;
  int   a_acc = 0, b_acc = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      a_pval = 1'b0;
    end else begin
      if (a_req_val && a_req_rdy) a_acc = cyc + 1;
      if (a_resp_val && !a_pval) begin
        if (qa.size() == 0) begin
          total++; bad++;
          $display("FAIL a_unexpected_resp: got resp_val=1 expected no response");
        end else check("a_latency", 64'(cyc - a_acc), 64'(qa[0].lat));
      end
      if (a_resp_val && a_resp_rdy && qa.size() > 0) begin
        e = qa.pop_front();
        check("a_resp_msg", 64'(a_resp_msg), 64'(e.msg));
      end
      a_pval = a_resp_val;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      b_pval = 1'b0;
    end else begin
      if (b_req_val && b_req_rdy) b_acc = cyc + 1;
      if (b_resp_val && !b_pval) begin
        if (qb.size() == 0) begin
          total++; bad++;
          $display("FAIL b_unexpected_resp: got resp_val=1 expected no response");
        end else check("b_latency", 64'(cyc - b_acc), 64'(qb[0].lat));
      end
      if (b_resp_val && b_resp_rdy && qb.size() > 0) begin
        e = qb.pop_front();
        check("b_resp_msg", 64'(b_resp_msg), 64'(e.msg));
      end
      b_pval = b_resp_val;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [N-1:0] msg, input logic loop, input logic [N-1:0] reply);
    exp_t e;
    bit   ok = 0;
    a_loop = loop;
    a_reply = reply;
    a_tx = msg;
    e.msg = loop ? msg : reply;
    e.lat = LAT_A;
    qa.push_back(e);
    a_req_msg = msg;
    a_req_val = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (a_req_rdy) begin ok = 1; break; end
    end
    if (!ok) begin total++; bad++; $display("FAIL a_accept_timeout: got req_rdy=0 expected 1"); end
    tick();
    a_req_val = 1'b0;
  endtask

  task automatic wait_resp_a();
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (a_resp_val && a_resp_rdy) begin ok = 1; break; end
    end
    if (!ok) begin total++; bad++; $display("FAIL a_resp_timeout: got no handshake expected one"); end
    tick();
  endtask

  initial begin
    logic [63:0] r64;
    int          rv_cnt;
    int          acc_cyc[3];
    logic [N-1:0] bmsg[3];
    exp_t        e;
    bit          ok;

    // Reset with random inputs
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      r64 = {$urandom, $urandom};
      a_req_val = r64[40]; a_resp_rdy = r64[41]; a_req_msg = r64[N-1:0];
      b_req_val = r64[42]; b_resp_rdy = r64[43]; b_req_msg = ~r64[N-1:0];
      tick();
    end
    @(negedge clk);
    check("rst_cs", 64'(a_cs), 64'd1);
    check("rst_sclk", 64'(a_sclk), 64'd0);
    check("rst_mosi", 64'(a_mosi), 64'd0);
    check("rst_resp_val", 64'(a_resp_val), 64'd0);
    check("rst_resp_msg", 64'(a_resp_msg), 64'd0);
    check("rst_req_rdy", 64'(a_req_rdy), 64'd1);
    check("rst_busy", 64'(a_busy), 64'd0);
    check("rst_b_cs_rdy", 64'({b_cs, b_req_rdy, b_busy}), 64'b110);
    tick();
    a_req_val = 1'b0; a_resp_rdy = 1'b1; a_req_msg = '0;
    b_req_val = 1'b0; b_resp_rdy = 1'b1; b_req_msg = '0;
    reset = 1'b1;
    tick();

    // Loopback
    send_a(34'h2_DEADBEEF, 1'b1, '0);
    wait_resp_a();

    // Minion returns a fixed word while MOSI stays 0
    send_a(34'h0, 1'b0, 34'h1_23456789);
    wait_resp_a();

    // Backpressure with the next request already waiting
    a_resp_rdy = 1'b0;
    send_a(34'h1_5555AAAA, 1'b1, '0);
    e.msg = 34'h0_00001234; e.lat = LAT_A;
    a_req_msg = e.msg;
    a_req_val = 1'b1;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (a_resp_val) begin ok = 1; break; end
    end
    check("bp_resp_seen", 64'(ok), 64'd1);
    for (int i = 0; i < 10; i++) begin
      check("bp_hold", {a_resp_val, a_resp_msg, a_req_rdy, a_cs, a_sclk},
            {1'b1, 34'h1_5555AAAA, 1'b0, 1'b1, 1'b0});
      @(negedge clk);
    end
    @(posedge clk); #1;
    a_tx = e.msg;
    qa.push_back(e);
    a_resp_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_accept_next", 64'({a_req_rdy, a_req_val}), 64'b11);
    tick();
    a_req_val = 1'b0;
    @(negedge clk);
    check("bp_busy_after_accept", 64'(a_busy), 64'd1);
    wait_resp_a();

    // Reset mid-frame after 10 sclk rises
    send_a(34'h2_AAAA5555, 1'b1, '0);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (a_rises >= 10) begin ok = 1; break; end
    end
    check("mid_reached_10", 64'(ok), 64'd1);
    #2;
    check("mid_cs_before", 64'(a_cs), 64'd0);
    reset = 1'b0;
    #1;
    check("mid_async", 64'({a_cs, a_sclk, a_busy, a_resp_val}), 64'b1000);
    qa.delete();
    repeat (3) tick();
    reset = 1'b1;
    rv_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (a_resp_val) rv_cnt++;
    end
    check("mid_no_resp", 64'(rv_cnt), 64'd0);
    tick();
    send_a(34'h0_0000000F, 1'b1, '0);
    wait_resp_a();

    // HALF=1 back-to-back frames
    bmsg[0] = 34'h3_FFFF0000;
    bmsg[1] = 34'h0_12345678;
    bmsg[2] = 34'h2_0000FFFF;
    for (int k = 0; k < 3; k++) begin
      e.msg = bmsg[k]; e.lat = LAT_B;
      qb.push_back(e);
    end
    b_req_val = 1'b1;
    for (int k = 0; k < 3; k++) begin
      b_req_msg = bmsg[k];
      ok = 0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (b_req_rdy) begin ok = 1; break; end
      end
      if (!ok) begin total++; bad++; $display("FAIL b_accept_timeout: got req_rdy=0 expected 1"); end
      acc_cyc[k] = cyc + 1;
      tick();
    end
    b_req_val = 1'b0;
    check("b_period_1", 64'(acc_cyc[1] - acc_cyc[0]), 64'(LAT_B + 2));
    check("b_period_2", 64'(acc_cyc[2] - acc_cyc[1]), 64'(LAT_B + 2));
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (qb.size() == 0 && !b_busy) begin ok = 1; break; end
    end
    check("b_drained", 64'(ok), 64'd1);
    check("b_frames", 64'(b_frames), 64'd3);

    repeat (5) tick();
    check("a_queue_empty", 64'(qa.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_master.md
# spi_master

SPI master that drives the four-wire minion interface of the group SPI tapeout block from the controller side: chip select, serial clock, MOSI out, MISO in. It accepts one NBITS-wide request message over a val/rdy handshake, shifts it out MSB-first in SPI mode 0 while shifting in the minion's reply, then presents the received NBITS-wide word on a val/rdy response interface. It sits in the test-harness/host FPGA side of the design, opposite the minion pads.

## Interface

- NBITS, 34, frame length in bits (32 data + 2 flow-control bits of the minion packet); legal range ≥ 2
- HALF, 2, clk cycles per SCLK half-period; legal range ≥ 1

- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- req_val  input  1  request message valid
- req_rdy  output  1  master ready to accept request
- req_msg  input  NBITS  word to transmit, bit NBITS-1 sent first
- resp_val  output  1  received word valid
- resp_rdy  input  1  consumer ready for received word
- resp_msg  output  NBITS  received word, first-received bit in bit NBITS-1
- spi_cs  output  1  chip select, active-low
- spi_sclk  output  1  serial clock, idle low
- spi_mosi  output  1  master-out data
- spi_miso  input  1  master-in data
- busy  output  1  high in every state except IDLE

## Operation

- States: IDLE, LEAD, HI, LO, TRAIL, GAP, RESP. Each of LEAD/HI/LO/TRAIL/GAP lasts exactly HALF cycles (timer counts HALF-1 down to 0); RESP lasts until handshake.
- IDLE: req_rdy=1 (combinational on state). req_val&&req_rdy: load shift register with req_msg, bit counter=0, go LEAD.
- LEAD: spi_cs=0, spi_sclk=0, spi_mosi=shift[NBITS-1]. → HI.
- Transition into HI: spi_sclk←1 and, on the same clk edge, spi_miso is sampled into the receive register LSB (receive register shifts left).
- HI: if bit counter==NBITS-1 → TRAIL, else → LO, with spi_mosi advancing to next bit and counter+1 on that edge (MOSI changes with SCLK falling).
- LO: spi_sclk=0 → HI.
- TRAIL: spi_sclk=0, spi_cs=0 → GAP.
- GAP: spi_cs=1 (guaranteed minimum deselect time) → RESP.
- RESP: resp_val=1, resp_msg=received word (stable while resp_val). resp_val&&resp_rdy → IDLE. req_rdy=0 in RESP; a new request is never accepted the same cycle as the response handshake.
- Exactly NBITS rising SCLK edges per frame; spi_cs low from LEAD through TRAIL only.
- All SPI outputs driven from flops (glitch-free).
- spi_miso is not synchronized inside; the minion drives it on SCLK falling edge, giving one half-period of setup.

## Timing

- Reset values: spi_cs=1, spi_sclk=0, spi_mosi=0, resp_val=0, resp_msg=0, busy=0, req_rdy=1, state IDLE, counters 0.
- Reset is asynchronous: asserting reset mid-frame immediately forces reset values (spi_cs rises in the same instant); the partial frame is discarded, no response is produced.
- Request accepted on edge 0 → spi_cs low from edge 1; first SCLK rise at edge 1+HALF.
- Latency acceptance → resp_val high: HALF·(2·NBITS+2) cycles (140 for defaults).
- Throughput: one frame per HALF·(2·NBITS+2)+2 cycles with resp_rdy tied high.
- resp_rdy held low: stays in RESP indefinitely, spi_cs=1, spi_sclk=0, req_rdy=0.
- HALF=1: each phase is one cycle; SCLK = clk/2.

## Test plan

- Reset: hold reset=0 with random inputs -> spi_cs=1, spi_sclk=0, spi_mosi=0, resp_val=0, req_rdy=1, busy=0.
- Loopback (spi_miso=spi_mosi), defaults, req_msg=34'h2_DEADBEEF -> 34 SCLK rises, MOSI bits MSB-first, resp_val high exactly 140 cycles after acceptance, resp_msg=34'h2_DEADBEEF.
- Mode-0 minion model returning 34'h1_23456789, req_msg=0 -> resp_msg=34'h1_23456789; MOSI constant 0; MOSI never changes while spi_sclk=1.
- Backpressure: resp_rdy=0 for 10 cycles after resp_val, req_val held 1 -> resp_val and resp_msg stable, req_rdy=0, spi_cs=1; accepted 1 cycle after resp handshake.
- Reset mid-frame after 10 SCLK rises -> spi_cs=1 asynchronously, no resp_val; next request 34'h0_0000000F completes correctly with loopback.
- HALF=1 back-to-back 3 frames, resp_rdy=1 -> spi_cs high ≥1 cycle between frames, 34 SCLK rises per frame, each frame 70 cycles to resp_val.
